// File: rtl/mv_pkg.sv
// Shared widths, limits and the FSM state type for the matrix-vector sequencer.
package mv_pkg;

  localparam int N_MAX  = 128;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int A_AW   = 14;
  localparam int X_AW   = 7;
  localparam int N_W    = 8;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  // A length is usable only when it addresses at least one and at most N_MAX elements.
  function automatic logic nValid(input logic [N_W-1:0] n);
    return (n != '0) && (n <= N_W'(N_MAX));
  endfunction

endpackage

// File: rtl/mv_mac.sv
// Registered unsigned multiply-accumulate; clear has priority over accumulate.
module mv_mac
  import mv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
);

  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  r_acc;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mv_sequencer.sv
// Walks A row-major against X, accumulating one dot product per row and writing it to Y.
module mv_sequencer
  import mv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic [N_W-1:0]    n_in,
  output logic              a_en_out,
  output logic [A_AW-1:0]   a_addr_out,
  input  logic [DATA_W-1:0] a_dout_in,
  output logic              x_en_out,
  output logic [X_AW-1:0]   x_addr_out,
  input  logic [DATA_W-1:0] x_dout_in,
  output logic              y_we_out,
  output logic [X_AW-1:0]   y_addr_out,
  output logic [ACC_W-1:0]  y_din_out,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);

  state_t          r_state;
  logic [N_W-1:0]  r_n;
  logic [X_AW-1:0] r_row;
  logic [X_AW-1:0] r_col;
  logic [A_AW-1:0] r_rowBase;
  logic [A_AW-1:0] r_aAddr;
  logic            r_aEn;
  logic            r_xEn;
  logic            r_yWe;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_rdValid;

  logic             w_lastCol;
  logic             w_lastRow;
  logic             w_clr;
  logic [A_AW-1:0]  w_nextBase;
  logic [ACC_W-1:0] w_acc;

  assign w_lastCol  = ({1'b0, r_col} == (r_n - N_W'(1)));
  assign w_lastRow  = ({1'b0, r_row} == (r_n - N_W'(1)));
  assign w_nextBase = r_rowBase + A_AW'(r_n);
  // The accumulator is held at zero while idle and wiped right after each row is written.
  assign w_clr      = (r_state == S_IDLE) || (r_state == S_WRITE);

  mv_mac u_mac (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_clr),
    .i_en  (r_rdValid),
    .i_a   (a_dout_in),
    .i_b   (x_dout_in),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_rowBase <= '0;
      r_aAddr   <= '0;
      r_aEn     <= 1'b0;
      r_xEn     <= 1'b0;
      r_yWe     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdValid <= 1'b0;
    end else begin
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_yWe     <= 1'b0;
      // Read data arrives one cycle after the enable, so the MAC follows the enable by one.
      r_rdValid <= r_aEn;
      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            if (nValid(n_in)) begin
              r_n       <= n_in;
              r_row     <= '0;
              r_col     <= '0;
              r_rowBase <= '0;
              r_aAddr   <= '0;
              r_aEn     <= 1'b1;
              r_xEn     <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_lastCol) begin
            r_aEn   <= 1'b0;
            r_xEn   <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            r_col   <= r_col + X_AW'(1);
            r_aAddr <= r_aAddr + A_AW'(1);
          end
        end
        S_FLUSH: begin
          r_yWe   <= 1'b1;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (w_lastRow) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row     <= r_row + X_AW'(1);
            r_rowBase <= w_nextBase;
            r_aAddr   <= w_nextBase;
            r_col     <= '0;
            r_aEn     <= 1'b1;
            r_xEn     <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a_en_out   = r_aEn;
  assign a_addr_out = r_aAddr;
  assign x_en_out   = r_xEn;
  assign x_addr_out = r_col;
  assign y_we_out   = r_yWe;
  assign y_addr_out = r_row;
  assign y_din_out  = w_acc;
  assign busy_out   = r_busy;
  assign done_out   = r_done;
  assign err_out    = r_err;

endmodule

// File: tb/tb_mv_sequencer.sv
// Directed bench for mv_sequencer: memory models for A/X and a scoreboard queue of expected Y writes.
module tb_mv_sequencer;
  import mv_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic [N_W-1:0]    n_in;
  logic              a_en_out;
  logic [A_AW-1:0]   a_addr_out;
  logic [DATA_W-1:0] a_dout_in;
  logic              x_en_out;
  logic [X_AW-1:0]   x_addr_out;
  logic [DATA_W-1:0] x_dout_in;
  logic              y_we_out;
  logic [X_AW-1:0]   y_addr_out;
  logic [ACC_W-1:0]  y_din_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;

  logic [DATA_W-1:0] memA [16384];
  logic [DATA_W-1:0] memX [128];

  typedef struct {
    int addr;
    int data;
  } yExp_t;

  yExp_t yQ[$];
  int    vectors  = 0;
  int    failures = 0;

  mv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start_in   (start_in),
    .n_in       (n_in),
    .a_en_out   (a_en_out),
    .a_addr_out (a_addr_out),
    .a_dout_in  (a_dout_in),
    .x_en_out   (x_en_out),
    .x_addr_out (x_addr_out),
    .x_dout_in  (x_dout_in),
    .y_we_out   (y_we_out),
    .y_addr_out (y_addr_out),
    .y_din_out  (y_din_out),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .err_out    (err_out)
  );

  always #5 clk = ~clk;

  // One-cycle read latency memories, as seen by the sequencer in the real system.
  always @(posedge clk) begin
    if (a_en_out) a_dout_in <= memA[a_addr_out];
    if (x_en_out) x_dout_in <= memX[x_addr_out];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 32'({a_en_out, x_en_out, y_we_out, busy_out, done_out, err_out}), 32'd0);
    checkOutput({tag, "_a_addr"}, 32'(a_addr_out), 32'd0);
    checkOutput({tag, "_x_addr"}, 32'(x_addr_out), 32'd0);
    checkOutput({tag, "_y_addr"}, 32'(y_addr_out), 32'd0);
    checkOutput({tag, "_y_din"}, 32'(y_din_out), 32'd0);
  endtask

  task automatic applyBadStart(input int n);
    @(negedge clk);
    start_in = 1'b1;
    n_in     = N_W'(n);
    @(negedge clk);
    start_in = 1'b0;
    checkOutput($sformatf("err_pulse_n%0d", n), 32'(err_out), 32'd1);
    checkOutput($sformatf("err_quiet_n%0d", n), 32'({a_en_out, x_en_out, busy_out}), 32'd0);
    @(negedge clk);
    checkOutput($sformatf("err_clear_n%0d", n), 32'(err_out), 32'd0);
    checkOutput($sformatf("err_idle_n%0d", n), 32'({a_en_out, x_en_out, busy_out}), 32'd0);
  endtask

  // Runs one job of length n; againAt injects an ignored start, rstAt (if >= 0) aborts the job.
  task automatic applyStimulus(input int n, input int againAt, input int rstAt);
    int    runEnd;
    int    lastT;
    int    aExp;
    int    lastAddr;
    int    acc;
    yExp_t e;
    logic  expA;
    logic  expY;
    yQ.delete();
    for (int r = 0; r < n; r++) begin
      acc = 0;
      for (int c = 0; c < n; c++) acc += int'(memA[r*n+c]) * int'(memX[c]);
      e.addr = r;
      e.data = acc;
      if (rstAt < 0 || (r + 1) * (n + 2) <= rstAt) yQ.push_back(e);
    end
    runEnd   = n * (n + 2) + 1;
    lastT    = (rstAt < 0) ? runEnd + 1 : rstAt + 6;
    aExp     = 0;
    lastAddr = -1;
    @(negedge clk);
    start_in = 1'b1;
    n_in     = N_W'(n);
    for (int t = 1; t <= lastT; t++) begin
      @(negedge clk);
      start_in = (t == againAt);
      n_in     = (t == againAt) ? 8'd2 : N_W'(n);
      if (rstAt >= 0 && t > rstAt) begin
        if (t == rstAt + 1) begin
          checkAllZero($sformatf("rst_n%0d", n));
          rst = 1'b0;
        end else begin
          checkOutput($sformatf("post_rst@%0d", t),
                      32'({busy_out, done_out, y_we_out, a_en_out, x_en_out}), 32'd0);
        end
      end else begin
        expA = (t <= n * (n + 2)) && (((t - 1) % (n + 2)) < n);
        expY = (t <= n * (n + 2)) && ((t % (n + 2)) == 0);
        checkOutput($sformatf("a_en@%0d", t), 32'(a_en_out), 32'(expA));
        checkOutput($sformatf("x_en@%0d", t), 32'(x_en_out), 32'(expA));
        if (expA) begin
          checkOutput($sformatf("a_addr@%0d", t), 32'(a_addr_out), 32'(aExp));
          checkOutput($sformatf("x_addr@%0d", t), 32'(x_addr_out), 32'(aExp % n));
          lastAddr = int'(a_addr_out);
          aExp++;
        end
        checkOutput($sformatf("y_we@%0d", t), 32'(y_we_out), 32'(expY));
        if (y_we_out) begin
          if (yQ.size() == 0) begin
            checkOutput($sformatf("y_extra@%0d", t), 32'd1, 32'd0);
          end else begin
            e = yQ.pop_front();
            checkOutput($sformatf("y_addr@%0d", t), 32'(y_addr_out), 32'(e.addr));
            checkOutput($sformatf("y_din@%0d", t), 32'(y_din_out), 32'(e.data));
          end
        end
        checkOutput($sformatf("busy@%0d", t), 32'(busy_out), 32'(t <= runEnd));
        checkOutput($sformatf("done@%0d", t), 32'(done_out), 32'(t == runEnd));
        checkOutput($sformatf("err@%0d", t), 32'(err_out), 32'd0);
        if (t == rstAt) rst = 1'b1;
      end
    end
    checkOutput($sformatf("y_pending_n%0d", n), 32'(yQ.size()), 32'd0);
    if (rstAt < 0) checkOutput($sformatf("last_a_addr_n%0d", n), 32'(lastAddr), 32'(n * n - 1));
  endtask

  initial begin
    rst      = 1'b1;
    start_in = 1'b0;
    n_in     = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("idle");

    applyBadStart(0);
    applyBadStart(200);
    applyBadStart(129);

    memA[0] = 8'd3;
    memX[0] = 8'd5;
    applyStimulus(1, -1, -1);

    for (int i = 0; i < 16; i++) memA[i] = 8'd1;
    for (int i = 0; i < 4; i++) memX[i] = 8'(i + 1);
    applyStimulus(4, 3, -1);
    applyStimulus(4, -1, 8);
    applyStimulus(4, -1, -1);

    for (int i = 0; i < 25; i++) memA[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) memX[i] = 8'($urandom_range(0, 255));
    applyStimulus(5, -1, -1);

    for (int i = 0; i < 16384; i++) memA[i] = 8'd255;
    for (int i = 0; i < 128; i++) memX[i] = 8'd255;
    applyStimulus(128, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
